// File: rtl/rename_regfile_pkg.sv
// rtl/rename_regfile_pkg.sv - shared CPU definitions used by the register file and the ROB
package rename_regfile_pkg;

  localparam int CPU_REG_ADDR_WIDTH = 5;
  localparam int CPU_Q_WIDTH        = 4;
  localparam int CPU_REG_COUNT      = 1 << CPU_REG_ADDR_WIDTH;
  localparam int CPU_ZERO_REG       = 0;
  localparam int CPU_XLEN           = 32;

endpackage

// File: rtl/rename_regfile_rename_table.sv
// rtl/rename_regfile_rename_table.sv - per-register busy bit and producing ROB tag
// Enables arrive pre-qualified (register 0 already excluded); flush clears every busy bit.
module rename_table
  import rename_regfile_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = CPU_REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = CPU_Q_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      issue_en,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [Q_WIDTH-1:0]        issue_Q,
  input  logic                      commit_en,
  input  logic [REG_ADDR_WIDTH-1:0] commit_reg_addr,
  input  logic [Q_WIDTH-1:0]        Commit_Q,
  input  logic                      control_hazard,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [Q_WIDTH-1:0]        rs1_Q,
  output logic [Q_WIDTH-1:0]        rs2_Q
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy;
  logic [Q_WIDTH-1:0]  tag [NUM_REGS];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) tag[i] <= '0;
    end else if (rdy_in) begin
      if (control_hazard) begin
        busy <= '0;
      end else begin
        // A stale commit (tag already reissued) must leave the newer producer pending.
        if (commit_en && tag[commit_reg_addr] == Commit_Q)
          busy[commit_reg_addr] <= 1'b0;
        if (issue_en) begin
          busy[issue_rd] <= 1'b1;
          tag[issue_rd]  <= issue_Q;
        end
      end
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
  assign rs1_Q    = tag[rs1_addr];
  assign rs2_Q    = tag[rs2_addr];

endmodule

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - renamed architectural register file with two read ports
// Optional REGFILE_COMMIT_BYPASS_EN forwards a matching commit to the read ports in the same cycle.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = CPU_REG_ADDR_WIDTH,
  parameter int Q_WIDTH        = CPU_Q_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      has_issue,
  input  logic                      issue_writes_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [Q_WIDTH-1:0]        issue_Q,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [Q_WIDTH-1:0]        rs1_Q,
  output logic [Q_WIDTH-1:0]        rs2_Q,
  output logic [CPU_XLEN-1:0]       rs1_V,
  output logic [CPU_XLEN-1:0]       rs2_V,
  input  logic                      has_commit,
  input  logic                      commit_modify_regfile,
  input  logic [REG_ADDR_WIDTH-1:0] commit_reg_addr,
  input  logic [Q_WIDTH-1:0]        Commit_Q,
  input  logic [CPU_XLEN-1:0]       Commit_V,
  input  logic                      control_hazard
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(CPU_ZERO_REG);

  logic [CPU_XLEN-1:0] val [NUM_REGS];
  logic                issue_en, commit_en;
  logic                t1_busy, t2_busy;
  logic [Q_WIDTH-1:0]  t1_Q, t2_Q;

  assign issue_en  = has_issue && issue_writes_rd && (issue_rd != ZERO_ADDR) && !control_hazard;
  assign commit_en = has_commit && commit_modify_regfile && (commit_reg_addr != ZERO_ADDR);

  rename_table #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .Q_WIDTH        (Q_WIDTH)
  ) u_rename_table (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .issue_en        (issue_en),
    .issue_rd        (issue_rd),
    .issue_Q         (issue_Q),
    .commit_en       (commit_en),
    .commit_reg_addr (commit_reg_addr),
    .Commit_Q        (Commit_Q),
    .control_hazard  (control_hazard),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_busy        (t1_busy),
    .rs2_busy        (t2_busy),
    .rs1_Q           (t1_Q),
    .rs2_Q           (t2_Q)
  );

  // Commit data lands even during a flush; only rename state is discarded.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) val[i] <= '0;
    end else if (rdy_in && commit_en) begin
      val[commit_reg_addr] <= Commit_V;
    end
  end

  always_comb begin
    rs1_busy = t1_busy;
    rs1_Q    = t1_Q;
    rs1_V    = val[rs1_addr];
    rs2_busy = t2_busy;
    rs2_Q    = t2_Q;
    rs2_V    = val[rs2_addr];
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (rdy_in && commit_en && commit_reg_addr == rs1_addr && t1_busy && t1_Q == Commit_Q) begin
      rs1_busy = 1'b0;
      rs1_V    = Commit_V;
    end
    if (rdy_in && commit_en && commit_reg_addr == rs2_addr && t2_busy && t2_Q == Commit_Q) begin
      rs2_busy = 1'b0;
      rs2_V    = Commit_V;
    end
`endif
    if (rs1_addr == ZERO_ADDR) begin
      rs1_busy = 1'b0;
      rs1_Q    = '0;
      rs1_V    = '0;
    end
    if (rs2_addr == ZERO_ADDR) begin
      rs2_busy = 1'b0;
      rs2_Q    = '0;
      rs2_V    = '0;
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// tb/tb_rename_regfile.sv - vector table, corner sequences and random run against a reference model
module tb_rename_regfile;

  localparam int AW = 5;
  localparam int QW = 4;
  localparam int NR = 1 << AW;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, has_issue, issue_writes_rd;
  logic [AW-1:0] issue_rd, rs1_addr, rs2_addr, commit_reg_addr;
  logic [QW-1:0] issue_Q, Commit_Q, rs1_Q, rs2_Q;
  logic          rs1_busy, rs2_busy, has_commit, commit_modify_regfile, control_hazard;
  logic [31:0]   rs1_V, rs2_V, Commit_V;

  rename_regfile #(.REG_ADDR_WIDTH(AW), .Q_WIDTH(QW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .has_issue(has_issue), .issue_writes_rd(issue_writes_rd),
    .issue_rd(issue_rd), .issue_Q(issue_Q),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_Q(rs1_Q), .rs2_Q(rs2_Q), .rs1_V(rs1_V), .rs2_V(rs2_V),
    .has_commit(has_commit), .commit_modify_regfile(commit_modify_regfile),
    .commit_reg_addr(commit_reg_addr), .Commit_Q(Commit_Q), .Commit_V(Commit_V),
    .control_hazard(control_hazard)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic iss; logic iwr; logic [AW-1:0] ird; logic [QW-1:0] iq;
    logic [AW-1:0] r1; logic [AW-1:0] r2;
    logic com; logic cmod; logic [AW-1:0] cad; logic [QW-1:0] cq; logic [31:0] cv;
    logic haz; logic rdy;
  } in_t;

  typedef struct packed {
    in_t in;
    logic b1; logic [QW-1:0] q1; logic [31:0] v1;
    logic b2; logic [QW-1:0] q2; logic [31:0] v2;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0, n_total = 0;

  logic [31:0]   m_val  [NR];
  logic          m_busy [NR];
  logic [QW-1:0] m_tag  [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic in_t mk(int ird, int iq, int r1, int r2, int cad, int cq,
                             logic [31:0] cv, bit haz, bit rdy);
    in_t x = '0;
    x.iss = (ird >= 0); x.iwr = 1'b1; x.ird = (ird >= 0) ? AW'(ird) : '0; x.iq = QW'(iq);
    x.r1 = AW'(r1); x.r2 = AW'(r2);
    x.com = (cad >= 0); x.cmod = 1'b1; x.cad = (cad >= 0) ? AW'(cad) : '0; x.cq = QW'(cq);
    x.cv = cv; x.haz = haz; x.rdy = rdy;
    return x;
  endfunction

  task automatic row(input in_t x, input logic b1, input int q1, input logic [31:0] v1,
                     input logic b2, input int q2, input logic [31:0] v2);
    vec_t v;
    v.in = x; v.b1 = b1; v.q1 = QW'(q1); v.v1 = v1; v.b2 = b2; v.q2 = QW'(q2); v.v2 = v2;
    tbl.push_back(v);
  endtask

  task automatic set_in(input in_t x);
    has_issue = x.iss; issue_writes_rd = x.iwr; issue_rd = x.ird; issue_Q = x.iq;
    rs1_addr = x.r1; rs2_addr = x.r2;
    has_commit = x.com; commit_modify_regfile = x.cmod; commit_reg_addr = x.cad;
    Commit_Q = x.cq; Commit_V = x.cv; control_hazard = x.haz; rdy_in = x.rdy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
  endtask

  // Architectural rules: commit writes value and retires the matching producer; a later issue
  // to the same register wins; a flush drops all pending producers and any same-cycle issue.
  task automatic model_step(input in_t x);
    if (!x.rdy) return;
    if (x.com && x.cmod && x.cad != 0) begin
      m_val[x.cad] = x.cv;
      if (m_tag[x.cad] == x.cq) m_busy[x.cad] = 1'b0;
    end
    if (x.haz) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    end else if (x.iss && x.iwr && x.ird != 0) begin
      m_busy[x.ird] = 1'b1;
      m_tag[x.ird]  = x.iq;
    end
  endtask

  task automatic model_read(input in_t x, input logic [AW-1:0] a,
                            output logic b, output logic [QW-1:0] q, output logic [31:0] v);
    if (a == 0) begin
      b = 1'b0; q = '0; v = '0;
    end else begin
      b = m_busy[a]; q = m_tag[a]; v = m_val[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (x.rdy && x.com && x.cmod && x.cad == a && b && q == x.cq) begin b = 1'b0; v = x.cv; end
`endif
    end
  endtask

  task automatic check_model(input in_t x, input string tagname);
    logic b; logic [QW-1:0] q; logic [31:0] v;
    model_read(x, x.r1, b, q, v);
    chk({tagname, " rs1_busy"}, 32'(rs1_busy), 32'(b));
    chk({tagname, " rs1_Q"},    32'(rs1_Q),    32'(q));
    chk({tagname, " rs1_V"},    rs1_V,         v);
    model_read(x, x.r2, b, q, v);
    chk({tagname, " rs2_busy"}, 32'(rs2_busy), 32'(b));
    chk({tagname, " rs2_Q"},    32'(rs2_Q),    32'(q));
    chk({tagname, " rs2_V"},    rs2_V,         v);
  endtask

  // Assumes entry just after a rising edge; reads are sampled mid-cycle.
  task automatic finish_cycle(input in_t x);
    @(posedge clk_in);
    model_step(x);
    #1;
  endtask

  initial begin
    in_t x;
    bit byp;
`ifdef REGFILE_COMMIT_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    row(mk(-1,0, 5,0, -1,0,0,       0,1), 0,0,0,            0,0,0);
    row(mk( 3,7, 3,0, -1,0,0,       0,1), 0,0,0,            0,0,0);
    if (byp) row(mk(-1,0, 3,5, 3,7,'h1234, 0,1), 0,7,'h1234, 0,0,0);
    else     row(mk(-1,0, 3,5, 3,7,'h1234, 0,1), 1,7,0,      0,0,0);
    row(mk( 3,7, 3,0, -1,0,0,       0,1), 0,7,'h1234,       0,0,0);
    row(mk( 3,9, 3,0, -1,0,0,       0,1), 1,7,'h1234,       0,0,0);
    row(mk(-1,0, 3,0,  3,7,'hAA,    0,1), 1,9,'h1234,       0,0,0);
    row(mk( 4,2, 3,4,  4,1,'h55,    0,1), 1,9,'hAA,         0,0,0);
    row(mk( 0,5, 4,0, -1,0,0,       0,1), 1,2,'h55,         0,0,0);
    row(mk( 1,1, 0,3, -1,0,0,       0,1), 0,0,0,            1,9,'hAA);
    row(mk( 2,2, 1,2, -1,0,0,       0,1), 1,1,0,            0,0,0);
    row(mk( 5,3, 2,4, -1,0,0,       0,1), 1,2,0,            1,2,'h55);
    row(mk( 6,4, 5,6, -1,0,0,       0,1), 1,3,0,            0,0,0);
    row(mk( 8,5, 6,3,  7,0,'h99,    1,1), 1,4,0,            1,9,'hAA);
    row(mk(-1,0, 6,8, -1,0,0,       0,1), 0,4,0,            0,0,0);
    row(mk(-1,0, 7,1, -1,0,0,       0,1), 0,0,'h99,         0,1,0);
    row(mk( 9,6, 3,4, -1,0,0,       0,1), 0,9,'hAA,         0,2,'h55);
    row(mk(10,7, 9,10, 9,6,'h1111,  1,0), 1,6,0,            0,0,0);
    row(mk(-1,0, 9,10,-1,0,0,       0,1), 1,6,0,            0,0,0);
    row(mk( 6,3, 6,0, -1,0,0,       0,1), 0,4,0,            0,0,0);
    if (byp) row(mk(-1,0, 6,0, 6,3,'h77, 0,1), 0,3,'h77,    0,0,0);
    else     row(mk(-1,0, 6,0, 6,3,'h77, 0,1), 1,3,0,       0,0,0);
    row(mk(-1,0, 6,0, -1,0,0,       0,1), 0,3,'h77,         0,0,0);

    x = mk(3,7, 5,0, 3,7,'hDEAD, 0,1);
    set_in(x);
    rst_in = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset rs1_busy", 32'(rs1_busy), 0);
    chk("reset rs1_V",    rs1_V,         0);
    rst_in = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].in);
      #4;
      chk($sformatf("vec%0d rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].b1));
      chk($sformatf("vec%0d rs1_Q", i),    32'(rs1_Q),    32'(tbl[i].q1));
      chk($sformatf("vec%0d rs1_V", i),    rs1_V,         tbl[i].v1);
      chk($sformatf("vec%0d rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].b2));
      chk($sformatf("vec%0d rs2_Q", i),    32'(rs2_Q),    32'(tbl[i].q2));
      chk($sformatf("vec%0d rs2_V", i),    rs2_V,         tbl[i].v2);
      finish_cycle(tbl[i].in);
    end

    // Asynchronous reset mid-cycle while an issue and commit are being driven.
    x = mk(11,1, 6,3, 3,9,'hBEEF, 0,1);
    set_in(x);
    #2 rst_in = 1'b1;
    #1;
    chk("async rst rs1_V",    rs1_V,         0);
    chk("async rst rs2_busy", 32'(rs2_busy), 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
    x = mk(-1,0, 11,3, -1,0,0, 0,1);
    set_in(x);
    #4;
    chk("post rst rs1_busy", 32'(rs1_busy), 0);
    chk("post rst rs2_V",    rs2_V,         0);
    finish_cycle(x);

    for (int n = 0; n < 400; n++) begin
      x.iss  = ($urandom_range(0, 3) != 0);
      x.iwr  = ($urandom_range(0, 3) != 0);
      x.ird  = AW'($urandom_range(0, 7));
      x.iq   = QW'($urandom);
      x.r1   = AW'($urandom_range(0, 7));
      x.r2   = AW'($urandom_range(0, 7));
      x.com  = ($urandom_range(0, 1) != 0);
      x.cmod = ($urandom_range(0, 3) != 0);
      x.cad  = AW'($urandom_range(0, 7));
      x.cq   = (x.cad != 0 && $urandom_range(0, 1) != 0) ? m_tag[x.cad] : QW'($urandom);
      x.cv   = $urandom;
      x.haz  = ($urandom_range(0, 19) == 0);
      x.rdy  = ($urandom_range(0, 9) != 0);
      set_in(x);
      #4;
      check_model(x, $sformatf("rand%0d", n));
      finish_cycle(x);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
